// File: rtl/jk_pkg.sv
// Shared JK-drive definitions: drive codes, sequencer states and the JK
// excitation table used to turn a (current, target) pair into a {J,K} code.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // xmode picks how the excitation don't-care is filled: 0 -> x=0, 1 -> x=1.
  function automatic logic [1:0] jk_excite(input logic mq, input logic tgt,
                                           input logic xmode);
    logic [1:0] code;
    case ({mq, tgt})
      2'b00:   code = xmode ? JK_RST : JK_HOLD;
      2'b01:   code = xmode ? JK_TOG : JK_SET;
      2'b10:   code = xmode ? JK_TOG : JK_RST;
      default: code = xmode ? JK_SET : JK_HOLD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/jk_drive_seq_bit_fifo.sv
// DEPTH-entry, 1-bit-wide synchronous FIFO with occupancy-derived full/empty.
// Storage is not reset; only pointers and occupancy are.
module bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jk_drive_seq.sv
// Converts a stream of target bits into JK drive codes for an external flop,
// checks the flop's q two edges after each code and recovers via INIT/SETTLE.
module jk_drive_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XMODE = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic [1:0]       jk,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic XM = (XMODE != 0);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] jk_nxt;
  logic       mq;
  logic       fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       mismatch;
  logic       exp_p0;
  logic       exp_p1;
  logic       vld_p0;
  logic       vld_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign tgt_ready = ~fifo_full;
  assign push      = tgt_valid & tgt_ready;
  assign mismatch  = vld_p1 & (q_fb != exp_p1);
  // A mismatch wins over a pop so the pending target stays queued for the retry.
  assign pop       = (state == ST_RUN) & ~fifo_empty & ~mismatch;
  assign busy      = ~fifo_empty | vld_p0 | vld_p1 | (state != ST_RUN);

  bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tgt),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_RUN;
      ST_RUN:    if (mismatch) state_nxt = ST_INIT;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    jk_nxt = JK_HOLD;
    case (state)
      ST_INIT:   jk_nxt = JK_RST;
      ST_SETTLE: jk_nxt = JK_HOLD;
      ST_RUN:    if (pop) jk_nxt = jk_excite(mq, fifo_dout, XM);
      default:   jk_nxt = JK_HOLD;
    endcase
  end

  // p0: code registered to the flop, expected value captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jk     <= JK_HOLD;
      mq     <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      jk     <= jk_nxt;
      vld_p0 <= pop;
      if (state == ST_SETTLE) mq <= 1'b0;
      else if (pop)           mq <= fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) exp_p0 <= fifo_dout;
    exp_p1 <= exp_p0;
  end

  // p1: flop has sampled the code; its q is compared on the following edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      vld_p1 <= vld_p0 & ~mismatch;
      if (mismatch) begin
        err     <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_jk_drive_seq.sv
// Scoreboard bench for jk_drive_seq: three instances (XMODE=0 with a fault
// mux and 2-bit counter, XMODE=1, DEPTH=2) each driving a JK flop model.
module tb_jk_drive_seq;

  localparam int S_JK = 0, S_Q = 1, S_ERR = 2, S_CNT = 3, S_RDY = 4, S_BUSY = 5, S_TMO = 6;

  typedef struct {
    int         cyc;
    int         inst;
    int         sig;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tgt = 1'b0;
  logic va = 1'b0, vb = 1'b0, vc = 1'b0;
  logic fault = 1'b0;
  logic rdya, rdyb, rdyc, busya, busyb, busyc, erra, errb, errc;
  logic [1:0] ja, jb, jc;
  logic [1:0] cnta;
  logic [7:0] cntb, cntc;
  logic qa, qb, qc, qfa;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  event imm_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign qfa = fault ? 1'b0 : qa;

  jk_drive_seq #(.DEPTH(4), .XMODE(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(va), .tgt_ready(rdya),
    .q_fb(qfa), .jk(ja), .busy(busya), .err(erra), .err_cnt(cnta));
  jk_drive_seq #(.DEPTH(4), .XMODE(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(vb), .tgt_ready(rdyb),
    .q_fb(qb), .jk(jb), .busy(busyb), .err(errb), .err_cnt(cntb));
  jk_drive_seq #(.DEPTH(2), .XMODE(0), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(vc), .tgt_ready(rdyc),
    .q_fb(qc), .jk(jc), .busy(busyc), .err(errc), .err_cnt(cntc));

  function automatic logic flop_next(input logic q, input logic [1:0] j);
    case (j)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa <= 1'b0; qb <= 1'b0; qc <= 1'b0;
    end else begin
      qa <= flop_next(qa, ja); qb <= flop_next(qb, jb); qc <= flop_next(qc, jc);
    end
  end

  function automatic logic [7:0] peek(input int inst, input int sig);
    logic [7:0] v;
    v = 8'h00;
    case (sig)
      S_JK:   v = (inst == 0) ? {6'd0, ja}   : (inst == 1) ? {6'd0, jb}   : {6'd0, jc};
      S_Q:    v = (inst == 0) ? {7'd0, qa}   : (inst == 1) ? {7'd0, qb}   : {7'd0, qc};
      S_ERR:  v = (inst == 0) ? {7'd0, erra} : (inst == 1) ? {7'd0, errb} : {7'd0, errc};
      S_CNT:  v = (inst == 0) ? {6'd0, cnta} : (inst == 1) ? cntb : cntc;
      S_RDY:  v = (inst == 0) ? {7'd0, rdya} : (inst == 1) ? {7'd0, rdyb} : {7'd0, rdyc};
      S_BUSY: v = (inst == 0) ? {7'd0, busya}: (inst == 1) ? {7'd0, busyb}: {7'd0, busyc};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic string signame(input int sig);
    case (sig)
      S_JK: return "jk";   S_Q: return "q";     S_ERR: return "err";
      S_CNT: return "err_cnt"; S_RDY: return "tgt_ready"; S_BUSY: return "busy";
      default: return "timeout";
    endcase
  endfunction

  // Cycle -1 means "check now"; entries are kept sorted by due cycle.
  function automatic void expect_at(input int c, input int inst, input int sig,
                                    input logic [7:0] v);
    exp_t e;
    int   i;
    e.cyc = c; e.inst = inst; e.sig = sig; e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endfunction

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk or imm_ev);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.sig == S_TMO) begin
          failures++;
          $display("FAIL timeout inst=%0d at cycle %0d: got no progress, required completion", e.inst, cyc);
        end else begin
          act = peek(e.inst, e.sig);
          if (act !== e.val) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d: got %0h, required %0h",
                     signame(e.sig), e.inst, e.cyc, act, e.val);
          end
        end
      end
    end
  end

  task automatic fire_now();
    -> imm_ev;
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      expect_at(-1, 9, S_TMO, 8'h00);
      fire_now();
    end
  endtask

  // Called at a negedge: asserts rst mid-cycle, checks reset values at once,
  // releases on a later negedge and returns the cycle count at release.
  task automatic do_reset(output int base);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_at(-1, i, S_JK, 8'h00);
      expect_at(-1, i, S_ERR, 8'h00);
      expect_at(-1, i, S_CNT, 8'h00);
      expect_at(-1, i, S_RDY, 8'h01);
      expect_at(-1, i, S_BUSY, 8'h01);
    end
    fire_now();
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    fault = 1'b0;
    base  = cyc;
  endtask

  task automatic fault_shot(input logic [1:0] jk_exp, input logic [7:0] cnt_exp);
    int t;
    t = cyc + 1;
    expect_at(t + 1, 0, S_JK, {6'd0, jk_exp});
    expect_at(t + 3, 0, S_ERR, 8'h01);
    expect_at(t + 3, 0, S_CNT, cnt_exp);
    expect_at(t + 3, 0, S_JK, 8'h00);
    expect_at(t + 4, 0, S_JK, 8'h01);
    expect_at(t + 4, 0, S_BUSY, 8'h01);
    expect_at(t + 5, 0, S_JK, 8'h00);
    expect_at(t + 5, 0, S_BUSY, 8'h00);
    tgt = 1'b1; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    drain();
  endtask

  initial begin : stimulus
    int         b;
    int         t;
    int         i;
    int         g;
    logic       acc;
    logic       seq2 [5];
    logic [1:0] jk0 [5];
    logic [1:0] jk1 [5];
    logic       qx  [5];
    logic       seq3 [5];
    logic [1:0] jk3 [5];
    logic       q3  [5];
    seq2 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    jk0  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    jk1  = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    qx   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    seq3 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    jk3  = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
    q3   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset values, then INIT (01) / SETTLE (00) and busy falling in RUN.
    @(negedge clk);
    do_reset(b);
    for (int k = 0; k < 3; k++) begin
      expect_at(b + 1, k, S_JK, 8'h01);
      expect_at(b + 1, k, S_BUSY, 8'h01);
      expect_at(b + 2, k, S_JK, 8'h00);
      expect_at(b + 2, k, S_BUSY, 8'h00);
      expect_at(b + 3, k, S_JK, 8'h00);
    end
    drain();

    // Targets 1,1,0,0,1 into XMODE=0 (inst 0) and XMODE=1 (inst 1).
    t = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      expect_at(t + 1 + k, 0, S_JK, {6'd0, jk0[k]});
      expect_at(t + 1 + k, 1, S_JK, {6'd0, jk1[k]});
      expect_at(t + 2 + k, 0, S_Q, {7'd0, qx[k]});
      expect_at(t + 2 + k, 1, S_Q, {7'd0, qx[k]});
    end
    for (int k = 0; k < 2; k++) begin
      expect_at(t + 6, k, S_JK, 8'h00);
      expect_at(t + 6, k, S_BUSY, 8'h01);
      expect_at(t + 7, k, S_BUSY, 8'h00);
      expect_at(t + 8, k, S_ERR, 8'h00);
      expect_at(t + 8, k, S_CNT, 8'h00);
    end
    for (int k = 0; k < 5; k++) begin
      tgt = seq2[k]; va = 1'b1; vb = 1'b1;
      @(negedge clk);
    end
    va = 1'b0; vb = 1'b0;
    drain();

    // Backpressure on the DEPTH=2 instance, pushing from reset release.
    do_reset(b);
    expect_at(b + 1, 2, S_RDY, 8'h01);
    expect_at(b + 2, 2, S_RDY, 8'h00);
    expect_at(b + 3, 2, S_RDY, 8'h01);
    for (int k = 0; k < 5; k++) begin
      expect_at(b + 3 + k, 2, S_JK, {6'd0, jk3[k]});
      expect_at(b + 4 + k, 2, S_Q, {7'd0, q3[k]});
    end
    expect_at(b + 8, 2, S_JK, 8'h00);
    expect_at(b + 9, 2, S_ERR, 8'h00);
    i = 0;
    g = 0;
    while (i < 5 && g < 50) begin
      tgt = seq3[i]; vc = 1'b1;
      acc = rdyc;
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    vc = 1'b0;
    if (i < 5) begin
      expect_at(-1, 2, S_TMO, 8'h00);
      fire_now();
    end
    drain();

    // Feedback stuck at 0: error, recovery sequence, counter saturating at 3.
    fault = 1'b1;
    fault_shot(2'b10, 8'h01);
    fault_shot(2'b10, 8'h02);
    fault_shot(2'b10, 8'h03);
    fault_shot(2'b10, 8'h03);

    // Three targets queued behind a mismatch, then reset mid-stream.
    t = cyc + 1;
    expect_at(t + 1, 0, S_JK, 8'h02);
    expect_at(t + 3, 0, S_CNT, 8'h03);
    expect_at(t + 3, 0, S_ERR, 8'h01);
    expect_at(t + 4, 0, S_JK, 8'h01);
    expect_at(t + 5, 0, S_JK, 8'h00);
    expect_at(t + 5, 0, S_BUSY, 8'h01);
    expect_at(t + 5, 0, S_RDY, 8'h01);
    tgt = 1'b1; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tgt = 1'b0; va = 1'b1;
    @(negedge clk);
    tgt = 1'b1;
    @(negedge clk);
    tgt = 1'b0;
    @(negedge clk);
    va = 1'b0;
    do_reset(b);
    expect_at(b + 1, 0, S_JK, 8'h01);
    expect_at(b + 2, 0, S_JK, 8'h00);
    expect_at(b + 2, 0, S_BUSY, 8'h00);
    expect_at(b + 3, 0, S_JK, 8'h00);
    expect_at(b + 4, 0, S_JK, 8'h00);
    expect_at(b + 3, 0, S_Q, 8'h00);
    expect_at(b + 4, 0, S_Q, 8'h00);
    expect_at(b + 4, 0, S_ERR, 8'h00);
    expect_at(b + 4, 0, S_CNT, 8'h00);
    drain();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
